dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (dmem) between two requesters:
  - Port 0: the pipeline memory stage.
  - Port 1: an auxiliary requester, e.g. a debug or program-loader engine.
- Port 0 has fixed priority. A starvation counter periodically forces a one-cycle grant to port 1 and stalls the pipeline for that cycle.
- Sits between the memory stage / aux master and the dmem instance. Also returns read-valid strobes to the requester that owns each read.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port 1 may be denied before a forced grant. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pipe_flush  in  1  squashes the current port-0 request.
- p0_req  in  1  pipeline access this cycle (read or write).
- p0_read  in  1  pipeline read enable.
- p0_writeb  in  4  pipeline byte write enables, already encoded.
- p0_addr  in  11  pipeline word address (byte address bits 12:2).
- p0_wdata  in  32  pipeline write data, already lane-encoded.
- p0_stall  out  1  pipeline must hold its memory-stage request this cycle.
- p0_rvalid  out  1  m_rdata belongs to port 0 this cycle.
- p1_req  in  1  aux request; held stable until granted.
- p1_read  in  1  aux read enable.
- p1_writeb  in  4  aux byte write enables.
- p1_addr  in  11  aux word address.
- p1_wdata  in  32  aux write data.
- p1_gnt  out  1  aux request accepted this cycle.
- p1_rvalid  out  1  m_rdata belongs to port 1 this cycle.
- m_read  out  1  dmem read enable.
- m_writeb  out  4  dmem byte write enables.
- m_addr  out  11  dmem word address.
- m_wdata  out  32  dmem write data.

Behaviour:
- Effective port-0 request: p0_act = p0_req & ~pipe_flush.
  - A flushed request never reaches dmem.
  - A flushed request is not stalled.
- State machine, two states, reset state RUN:
  - RUN, port 0 wins:
    - If p0_act: grant port 0.
    - Else if p1_req: grant port 1 (p1_gnt=1).
  - RUN, denial counting:
    - The counter increments on each cycle with p1_req=1 and no port-1 grant.
    - The counter clears on any port-1 grant, or when p1_req=0.
  - RUN -> FORCE: when p1_req & p0_act & (cnt == STARVE_LIMIT-1) at a clock edge.
  - FORCE, lasts exactly one cycle:
    - Grant port 1 unconditionally; p1_gnt=1.
    - p0_stall = p0_act.
    - Counter clears.
    - Next state RUN.
  - FORCE with p1_req=0 (protocol violation): no grant, p0 granted normally, p0_stall=0, return to RUN.
- Grant muxing is combinational, same cycle:
  - m_* take the granted port's fields.
  - With no grant, all m_* are 0, so no spurious write ever occurs.
- p0_stall is 0 in RUN, always.
- Read return:
  - rtag register captures {granted-read, owner} at each edge.
  - Next cycle: p0_rvalid or p1_rvalid = 1 per rtag, aligned with m_rdata (1-cycle dmem latency).
  - Writes produce no rvalid.
- Stall retry: a stalled port-0 read is granted in the following RUN cycle. Its rvalid comes one cycle after that grant.
- Reset, asynchronous on rst_n low:
  - Registers: state=RUN, cnt=0, rtag=0, so p0_rvalid=0 and p1_rvalid=0.
  - Outputs while rst_n=0: m_read=0, m_writeb=0, p1_gnt=0, p0_stall=0.
  - A read granted the cycle before reset asserts produces no rvalid after reset.
- Counter saturates at STARVE_LIMIT-1 and never wraps.
- With STARVE_LIMIT=1, a single denial forces the next cycle, giving strict alternation under contention.

Test Plan:
- Port 0 only: p0_req=1, p0_read=1, p0_addr=0x010 -> m_read=1, m_addr=0x010 same cycle; p0_rvalid=1 next cycle; p1_gnt=0.
- Port 1 only: p1_req=1, p1_writeb=4'b1111, p1_addr=0x7FF, p1_wdata=0xDEADBEEF -> p1_gnt=1 same cycle; m_writeb=4'b1111; no rvalid.
- Starvation, STARVE_LIMIT=4: p0_act and p1_req held high -> p1 denied cycles 0..3; cycle 4 is FORCE with p1_gnt=1 and p0_stall=1; cycle 5 returns to p0; denial count restarts.
- Flush: p0_req=1, p0_writeb=4'b0011, pipe_flush=1, p1_req=0 -> m_writeb=0, p0_stall=0; the same cycle with p1_req=1 -> p1 granted.
- Stalled read: port-0 read stalled in FORCE at cycle N -> re-granted at N+1; p0_rvalid=1 at N+2 only; p1_rvalid=1 at N+1 (if port 1 read).
- Reset mid-operation: assert rst_n=0 the cycle after a granted read -> p0_rvalid=0 immediately; after release, state=RUN and cnt=0 (the first contention cycle still denies port 1).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: the pipeline has
// fixed priority, and a starvation counter periodically forces a grant to the aux port.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic        p0_req,
  input  logic        p0_read,
  input  logic [3:0]  p0_writeb,
  input  logic [10:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_stall,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_read,
  input  logic [3:0]  p1_writeb,
  input  logic [10:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic        m_read,
  output logic [3:0]  m_writeb,
  output logic [10:0] m_addr,
  output logic [31:0] m_wdata
);

  typedef enum logic {RUN, FORCE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             p0_act;
  logic             gnt0, gnt1;
  logic             rtag_read, rtag_owner;

  assign p0_act = p0_req & ~pipe_flush;

  // Grants are forced low while rst_n is asserted so no access leaks out during reset.
  always_comb begin
    state_nxt = RUN;
    cnt_nxt   = '0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    p0_stall  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (p0_act) begin
            gnt0 = 1'b1;
          end else if (p1_req) begin
            gnt1 = 1'b1;
          end
          if (p1_req && !gnt1) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            if (p0_act && (cnt == CNT_MAX)) begin
              state_nxt = FORCE;
            end
          end
        end
        FORCE: begin
          // A missing aux request here is a protocol slip; fall back to serving port 0.
          if (p1_req) begin
            gnt1     = 1'b1;
            p0_stall = p0_act;
          end else begin
            gnt0 = p0_act;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_comb begin
    m_read   = 1'b0;
    m_writeb = 4'b0000;
    m_addr   = '0;
    m_wdata  = '0;
    if (gnt0) begin
      m_read   = p0_read;
      m_writeb = p0_writeb;
      m_addr   = p0_addr;
      m_wdata  = p0_wdata;
    end else if (gnt1) begin
      m_read   = p1_read;
      m_writeb = p1_writeb;
      m_addr   = p1_addr;
      m_wdata  = p1_wdata;
    end
  end

  assign p1_gnt = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The read tag lines up with the one-cycle dmem read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtag_read  <= 1'b0;
      rtag_owner <= 1'b0;
    end else begin
      rtag_read  <= m_read;
      rtag_owner <= gnt1;
    end
  end

  assign p0_rvalid = rtag_read & ~rtag_owner;
  assign p1_rvalid = rtag_read & rtag_owner;

endmodule
